// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Definitions shared by the cordic sin/cos engine and the blocks that feed it.
//   THETA_W      : width of the theta phase word handed to cordic
//   nco_state_e  : phase-generator control states
//   hs_xfer()    : valid/ready handshake transfer condition
// -----------------------------------------------------------------------------
package cordic_pkg;

    localparam int unsigned THETA_W = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } nco_state_e;

    // A word moves on any edge where the producer offers it and the consumer takes it.
    function automatic logic hs_xfer(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/nco_phase_acc.sv
// -----------------------------------------------------------------------------
// nco_phase_acc
// Phase accumulator register plus theta adder for the NCO.
// Ports:
//   clk        : clock
//   rstb       : synchronous active-low reset, clears the accumulator
//   clr        : clear the accumulator at the next edge (start of a run)
//   adv        : advance the accumulator by ftw at the next edge
//   ftw        : frequency tuning word (ACC_W bits)
//   phase_off  : constant phase offset added to the accumulator's top bits
//   theta_next : theta that belongs to the accumulator value after advancing
// -----------------------------------------------------------------------------
module nco_phase_acc
    import cordic_pkg::*;
#(
    parameter int unsigned ACC_W = 24
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               clr,
    input  logic               adv,
    input  logic [ACC_W-1:0]   ftw,
    input  logic [THETA_W-1:0] phase_off,
    output logic [THETA_W-1:0] theta_next
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] acc_sum;

    // Modular add; the carry out of the top bit is simply dropped.
    always_comb begin
        acc_sum = acc_q + ftw;
    end

    // clr has priority so a run always starts from phase zero.
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (adv) begin
            acc_d = acc_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // theta tracks the accumulator's top THETA_W bits, offset mod 2^THETA_W.
    assign theta_next = acc_sum[ACC_W-1 -: THETA_W] + phase_off;

endmodule

// File: rtl/nco_phase_gen.sv
// -----------------------------------------------------------------------------
// nco_phase_gen
// Numerically controlled phase generator feeding the cordic engine. Issues one
// theta at a time over the in_valid/ready handshake and advances the phase
// accumulator once per completed conversion. Runs a burst of num_samples, or
// runs continuously (num_samples = 0) until stop.
// Ports:
//   clk          : clock
//   rstb         : synchronous active-low reset
//   start        : begin a run (only honoured while idle)
//   stop         : abort the current run (no done pulse)
//   ftw          : frequency tuning word, latched on start
//   phase_off    : phase offset, latched on start
//   num_samples  : samples per run, latched on start; 0 = continuous
//   cordic_ready : cordic ready; also marks the cordic result as produced
//   theta        : phase word to cordic
//   theta_valid  : cordic in_valid
//   busy         : high whenever a run is in progress (including the done cycle)
//   done         : one-cycle pulse when a burst completes normally
//   sample_idx   : conversions completed in the current run
// -----------------------------------------------------------------------------
module nco_phase_gen
    import cordic_pkg::*;
#(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               start,
    input  logic               stop,
    input  logic [ACC_W-1:0]   ftw,
    input  logic [THETA_W-1:0] phase_off,
    input  logic [CNT_W-1:0]   num_samples,
    input  logic               cordic_ready,
    output logic [THETA_W-1:0] theta,
    output logic               theta_valid,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   sample_idx
);

    nco_state_e         state_q;
    logic [ACC_W-1:0]   ftw_q;
    logic [THETA_W-1:0] phase_off_q;
    logic [CNT_W-1:0]   num_samples_q;
    logic [CNT_W-1:0]   sample_idx_q;
    logic [THETA_W-1:0] theta_q;
    logic               theta_valid_q;
    logic               busy_q;
    logic               done_q;
    // Set on the transfer edge: cordic_ready is still high on the following
    // edge and must not be mistaken for a finished conversion.
    logic               guard_q;
    // Remembers a stop seen while a conversion is in flight.
    logic               stop_seen_q;

    logic               xfer;
    logic               run_go;
    logic               complete;
    logic               last_sample;
    logic [CNT_W-1:0]   sample_inc;
    logic [THETA_W-1:0] theta_next;

    always_comb begin
        xfer        = hs_xfer(theta_valid_q, cordic_ready);
        run_go      = (state_q == StIdle) && start && !stop;
        complete    = (state_q == StWait) && !guard_q && cordic_ready;
        sample_inc  = sample_idx_q + CNT_W'(1);
        last_sample = (num_samples_q != '0) && (sample_inc == num_samples_q);
    end

    nco_phase_acc #(
        .ACC_W (ACC_W)
    ) u_acc (
        .clk        (clk),
        .rstb       (rstb),
        .clr        (run_go),
        .adv        (complete),
        .ftw        (ftw_q),
        .phase_off  (phase_off_q),
        .theta_next (theta_next)
    );

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q       <= StIdle;
            ftw_q         <= '0;
            phase_off_q   <= '0;
            num_samples_q <= '0;
            sample_idx_q  <= '0;
            theta_q       <= '0;
            theta_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            guard_q       <= 1'b0;
            stop_seen_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    theta_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                    if (run_go) begin
                        ftw_q         <= ftw;
                        phase_off_q   <= phase_off;
                        num_samples_q <= num_samples;
                        sample_idx_q  <= '0;
                        // The accumulator restarts at zero, so the first sample is the offset.
                        theta_q       <= phase_off;
                        theta_valid_q <= 1'b1;
                        busy_q        <= 1'b1;
                        guard_q       <= 1'b0;
                        stop_seen_q   <= 1'b0;
                        state_q       <= StIssue;
                    end
                end

                StIssue: begin
                    if (xfer) begin
                        // A stop on the transfer edge is deferred until the result lands.
                        theta_valid_q <= 1'b0;
                        guard_q       <= 1'b1;
                        stop_seen_q   <= stop;
                        state_q       <= StWait;
                    end else if (stop) begin
                        theta_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= StIdle;
                    end
                end

                StWait: begin
                    guard_q <= 1'b0;
                    if (stop) begin
                        stop_seen_q <= 1'b1;
                    end
                    if (complete) begin
                        sample_idx_q <= sample_inc;
                        theta_q      <= theta_next;
                        if (stop_seen_q || stop) begin
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end else if (last_sample) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            theta_valid_q <= 1'b1;
                            state_q       <= StIssue;
                        end
                    end
                end

                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign theta       = theta_q;
    assign theta_valid = theta_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign sample_idx  = sample_idx_q;

endmodule

// File: tb/tb_nco_phase_gen.sv
// -----------------------------------------------------------------------------
// tb_nco_phase_gen
// Scoreboard bench: expected thetas are queued when a run is started, a monitor
// pops and compares on every handshake transfer. A small cordic model drives
// cordic_ready (ready stays high one cycle after a transfer, then low for a
// random latency while the conversion is in flight).
// -----------------------------------------------------------------------------
module tb_nco_phase_gen;

    localparam int ACC_W = 24;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rstb = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [ACC_W-1:0] ftw = '0;
    logic [15:0]      phase_off = '0;
    logic [CNT_W-1:0] num_samples = '0;
    logic             cordic_ready;
    logic [15:0]      theta;
    logic             theta_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_idx;

    always #5 clk = ~clk;

    nco_phase_gen #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rstb         (rstb),
        .start        (start),
        .stop         (stop),
        .ftw          (ftw),
        .phase_off    (phase_off),
        .num_samples  (num_samples),
        .cordic_ready (cordic_ready),
        .theta        (theta),
        .theta_valid  (theta_valid),
        .busy         (busy),
        .done         (done),
        .sample_idx   (sample_idx)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;
    int          xfer_cnt = 0;
    int          done_cnt = 0;

    // cordic model controls/state
    int unsigned lat_min = 1;
    int unsigned lat_max = 4;
    bit          force_low = 1'b0;
    int unsigned mdl_cnt = 0;
    bit          mdl_pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: sample k of a run is the top 16 bits of (k*ftw mod 2^24) plus offset.
    function automatic logic [15:0] ref_theta(input logic [23:0] f, input logic [15:0] o,
                                              input int k);
        longint unsigned p;
        logic [15:0]     r;
        p = (longint'(k) * longint'(f)) % 64'd16777216;
        r = 16'(p >> 8);
        r = r + o;
        return r;
    endfunction

    // cordic model: inputs sampled at negedge, ready updated just after posedge.
    initial begin
        bit x;
        cordic_ready = 1'b1;
        forever begin
            @(negedge clk);
            x = rstb && theta_valid && cordic_ready;
            @(posedge clk);
            #1;
            if (mdl_pend) begin
                mdl_pend = 1'b0;
                mdl_cnt  = $urandom_range(lat_max, lat_min);
            end else if (x) begin
                mdl_pend = 1'b1;
            end else if (mdl_cnt > 0) begin
                mdl_cnt--;
            end
            cordic_ready = !force_low && (mdl_cnt == 0);
        end
    end

    // Monitor: every transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rstb && theta_valid && cordic_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got theta %0h, expected no transfer", theta);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("theta", 32'(theta), 32'(mon_exp));
            end
        end
        if (rstb && done) begin
            done_cnt++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic start_run(input logic [23:0] f, input logic [15:0] o, input logic [15:0] n,
                             input int npush);
        @(posedge clk);
        #1;
        ftw         = f;
        phase_off   = o;
        num_samples = n;
        start       = 1'b1;
        for (int k = 0; k < npush; k++) begin
            exp_q.push_back(ref_theta(f, o, k));
        end
        @(posedge clk);
        #1;
        start       = 1'b0;
        // Inputs are free to change once latched.
        ftw         = 24'($urandom);
        phase_off   = 16'($urandom);
        num_samples = 16'($urandom);
    endtask

    task automatic wait_done(input int n, input int d0);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 3000 && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk("idx_at_done", 32'(sample_idx), 32'(n));
            chk("busy_in_done", 32'(busy), 32'd1);
            chk("result_landed", 32'((mdl_cnt == 0) && !mdl_pend), 32'd1);
            @(negedge clk);
            chk("busy_after_done", 32'(busy), 32'd0);
            chk("done_width", 32'(done), 32'd0);
        end
        chk("done_count", 32'(done_cnt - d0), 32'd1);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs();
        chk("rst_theta", 32'(theta), 32'd0);
        chk("rst_valid", 32'(theta_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_idx", 32'(sample_idx), 32'd0);
    endtask

    initial begin
        int          d0;
        int          x0;
        int          hits;
        logic [23:0] f;
        logic [15:0] o;
        logic [15:0] n;

        repeat (3) @(posedge clk);
        #1 rstb = 1'b1;
        @(negedge clk);
        check_reset_outputs();

        // Burst
        d0 = done_cnt;
        start_run(24'h040000, 16'h0000, 16'd4, 4);
        wait_done(4, d0);

        // Accumulator wrap with offset
        d0 = done_cnt;
        start_run(24'h800000, 16'h4000, 16'd3, 3);
        wait_done(3, d0);

        // Random bursts
        for (int r = 0; r < 6; r++) begin
            f  = 24'($urandom);
            o  = 16'($urandom);
            n  = 16'($urandom_range(6, 1));
            d0 = done_cnt;
            start_run(f, o, n, int'(n));
            wait_done(int'(n), d0);
        end

        // Stall in ISSUE
        @(negedge clk);
        force_low = 1'b1;
        repeat (2) @(posedge clk);
        d0 = done_cnt;
        x0 = xfer_cnt;
        start_run(24'($urandom), 16'h1234, 16'd2, 2);
        hits = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (theta_valid === 1'b1 && theta === 16'h1234) hits++;
        end
        chk("stall_hold", 32'(hits), 32'd5);
        chk("stall_no_xfer", 32'(xfer_cnt - x0), 32'd0);
        force_low = 1'b0;
        wait_done(2, d0);
        chk("stall_xfers", 32'(xfer_cnt - x0), 32'd2);

        // Stop during WAIT in continuous mode
        lat_min = 6;
        lat_max = 6;
        d0 = done_cnt;
        x0 = xfer_cnt;
        start_run(24'($urandom), 16'($urandom), 16'd0, 2);
        for (int t = 0; t < 500 && xfer_cnt < x0 + 2; t++) @(posedge clk);
        chk("stop_two_xfers", 32'(xfer_cnt - x0), 32'd2);
        repeat (3) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        for (int t = 0; t < 100 && busy; t++) @(negedge clk);
        @(negedge clk);
        chk("stop_idle", 32'(busy), 32'd0);
        chk("stop_idx", 32'(sample_idx), 32'd2);
        hits = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (theta_valid !== 1'b0 || done !== 1'b0) hits++;
        end
        chk("stop_quiet", 32'(hits), 32'd0);
        chk("stop_no_done", 32'(done_cnt - d0), 32'd0);
        chk("stop_xfers", 32'(xfer_cnt - x0), 32'd2);
        chk("stop_sb_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        lat_min = 1;
        lat_max = 4;

        // start re-pulsed mid-run is ignored
        f  = 24'($urandom);
        o  = 16'($urandom);
        d0 = done_cnt;
        x0 = xfer_cnt;
        start_run(f, o, 16'd5, 5);
        for (int t = 0; t < 500 && xfer_cnt < x0 + 2; t++) @(posedge clk);
        @(posedge clk);
        #1;
        start       = 1'b1;
        ftw         = ~f;
        phase_off   = ~o;
        num_samples = 16'd2;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(5, d0);

        // start and stop together in IDLE
        @(posedge clk);
        #1;
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        hits = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (busy !== 1'b0 || theta_valid !== 1'b0) hits++;
        end
        chk("start_stop_idle", 32'(hits), 32'd0);

        // Reset while in ISSUE
        @(negedge clk);
        force_low = 1'b1;
        repeat (2) @(posedge clk);
        start_run(24'($urandom), 16'($urandom), 16'd3, 0);
        @(negedge clk);
        chk("issue_before_rst", 32'(theta_valid), 32'd1);
        @(posedge clk);
        #1 rstb = 1'b0;
        @(posedge clk);
        #1 rstb = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        force_low = 1'b0;
        d0 = done_cnt;
        start_run(24'($urandom), 16'h0100, 16'd1, 1);
        wait_done(1, d0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nco_phase_gen.md
Name: nco_phase_gen

Overview:
Upstream stage for the cordic sin/cos engine: a numerically controlled phase generator that produces a stream of 16-bit theta values and hands them to cordic using its in_valid/ready handshake. A phase accumulator advances by a latched frequency tuning word once per completed conversion, plus a constant phase offset. It runs either a programmed burst of samples or continuously until stopped, so cordic sees exactly one outstanding request at a time.

Parameters:
ACC_W, 24, phase accumulator width; theta is the top 16 bits (ACC_W >= 16)
CNT_W, 16, width of the sample counter and num_samples

Ports:
clk  in  1  clock
rstb  in  1  synchronous active-low reset
start  in  1  begin a run (sampled only in IDLE)
stop  in  1  abort the run
ftw  in  ACC_W  frequency tuning word, latched on start
phase_off  in  16  phase offset added to theta, latched on start
num_samples  in  CNT_W  samples per run, latched on start; 0 = continuous
cordic_ready  in  1  cordic ready output
theta  out  16  phase to cordic theta
theta_valid  out  1  drives cordic in_valid
busy  out  1  high while not IDLE
done  out  1  one-cycle pulse at normal run completion
sample_idx  out  CNT_W  number of completed conversions in the current run

Behaviour:
- Single clock clk; reset is synchronous, active-low on rstb. Every flop is cleared on a clk edge with rstb=0.
- Reset values: theta=0, theta_valid=0, busy=0, done=0, sample_idx=0, accumulator=0, state=IDLE.
- Reset mid-run returns to IDLE immediately. No done is produced. An outstanding cordic result is ignored.
- Transfer occurs on an edge where theta_valid=1 and cordic_ready=1.
- States:
  - IDLE: theta_valid=0, busy=0.
    - start=1 and stop=0: latch ftw, phase_off and num_samples; clear the accumulator and sample_idx; register theta=phase_off; go to ISSUE. theta_valid is high the cycle after start.
    - start and stop together: stay IDLE.
  - ISSUE: theta_valid=1. theta is held stable while cordic_ready=0.
    - On transfer: go to WAIT and drop theta_valid at the next edge.
    - stop=1 with no transfer on that edge: go to IDLE, no done.
    - stop=1 on the same edge as a transfer: the transfer wins, then abort from WAIT.
  - WAIT: theta_valid=0. Wait for cordic_ready=1, which marks the cordic result as produced.
    - The edge right after transfer is ignored, because ready has not yet fallen. Implement this with a one-cycle guard flag.
    - On completion: sample_idx += 1 and acc += ftw (mod 2^ACC_W). theta = acc_next[ACC_W-1:ACC_W-16] + phase_off (mod 2^16).
    - If stop was seen at any time during this WAIT: go to IDLE, no done.
    - Else if num_samples != 0 and sample_idx+1 == num_samples: go to DONE.
    - Else go to ISSUE.
  - DONE: done=1 for exactly one cycle, then IDLE. busy remains 1 during DONE.
- start is ignored outside IDLE. ftw, phase_off and num_samples may change freely after latching.
- Continuous mode: sample_idx wraps at 2^CNT_W and is never a termination condition.
- The first sample of every run is phase_off; accumulator wrap is modular and silent.
- At most one request is outstanding; back-to-back theta spacing is set entirely by cordic_ready.

Decomposition:
- Shared package cordic_pkg:
  - THETA_W = 16
  - the nco state enum (IDLE, ISSUE, WAIT, DONE)
  - the handshake-transfer helper function
- Sub-module nco_phase_acc: accumulator register plus theta adder. Interface: clr, adv, ftw, phase_off -> theta_next.
- The FSM, latches and counter stay in nco_phase_gen.

Test Plan:
- Burst: ftw=24'h040000, phase_off=0, num_samples=4, cordic instance attached -> thetas 16'h0000, 16'h0400, 16'h0800, 16'h0C00 each accepted once; one done pulse; sample_idx=4; busy low the cycle after done.
- Wrap plus offset: ftw=24'h800000, phase_off=16'h4000, num_samples=3 -> thetas 16'h4000, 16'hC000, 16'h4000; done once.
- Stall: model cordic_ready held low 5 cycles while in ISSUE with theta=16'h1234 -> theta_valid stays high and theta is stable all 5 cycles; exactly one transfer when ready rises.
- Stop during WAIT: continuous mode (num_samples=0), stop pulsed 3 cycles after the 2nd transfer -> no further theta_valid; IDLE after that result; done never asserted; sample_idx=2.
- Start ignored when busy, and start+stop in IDLE: start re-pulsed mid-run -> run is unchanged and ftw is not relatched; start and stop together in IDLE -> busy stays 0.
- Reset mid-ISSUE: rstb=0 for 1 cycle while theta_valid=1 -> next cycle all outputs are at reset values; a new start with phase_off=16'h0100 yields first theta 16'h0100.
